// File: rtl/pattern_load_ctrl_if.sv
// Pattern ROM read port and grid memory write port of the pattern loader.
// The master side drives addresses and write requests; the slave side answers.
interface pattern_load_ctrl_if #(
    parameter int AW   = 4,
    parameter int COLS = 16
) ();
    logic [AW-1:0]   rom_addr;
    logic [COLS-1:0] rom_data;
    logic            grid_we;
    logic [AW-1:0]   grid_addr;
    logic [COLS-1:0] grid_wdata;
    logic            grid_ready;

    modport master (
        output rom_addr,
        input  rom_data,
        output grid_we,
        output grid_addr,
        output grid_wdata,
        input  grid_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  grid_we,
        input  grid_addr,
        input  grid_wdata,
        output grid_ready
    );
endinterface

// File: rtl/pattern_load_ctrl.sv
// Button-driven pattern selector and row-by-row ROM-to-grid loader.
// Buttons are registered twice; an edge acts one cycle after the rise.
module pattern_load_ctrl #(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int AW   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_load,
    input  logic       btn_run,
    output logic [1:0] sel,
    output logic [3:0] sel_onehot,
    output logic       run_en,
    output logic       busy,
    output logic       load_done,
    pattern_load_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_RUN
    } state_e;

    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [AW-1:0]   row_q, row_d;
    logic [COLS-1:0] wdata_q, wdata_d;
    logic            done_q, done_d;
    logic [2:0]      btn_cur_q, btn_prev_q;
    logic [2:0]      btn_edge;

    // bit 0 = next, bit 1 = load, bit 2 = run
    assign btn_edge = btn_cur_q & ~btn_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 2'd0;
            row_q      <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            btn_cur_q  <= 3'b000;
            btn_prev_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            row_q      <= row_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            btn_cur_q  <= {btn_run, btn_load, btn_next};
            btn_prev_q <= btn_cur_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        row_d   = row_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_RUN: begin
                // load takes priority and swallows next/run edges
                if (btn_edge[1]) begin
                    row_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    if (btn_edge[0]) begin
                        sel_d = sel_q + 2'd1;
                    end
                    if (btn_edge[2]) begin
                        state_d = (state_q == S_IDLE) ? S_RUN : S_IDLE;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdata_d = bus.rom_data;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (bus.grid_ready) begin
                    if (row_q == LAST_ROW) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel            = sel_q;
    assign sel_onehot     = 4'b0001 << sel_q;
    assign run_en         = (state_q == S_RUN);
    assign busy           = (state_q == S_FETCH) ||
                            (state_q == S_WAIT)  ||
                            (state_q == S_WRITE);
    assign load_done      = done_q;
    assign bus.rom_addr   = row_q;
    assign bus.grid_we    = (state_q == S_WRITE);
    assign bus.grid_addr  = row_q;
    assign bus.grid_wdata = wdata_q;

endmodule

// File: tb/tb_pattern_load_ctrl.sv
// Directed bench for pattern_load_ctrl: vector table for button handling,
// hand-written sequences for loads, write stalls, ignored edges and reset.
module tb_pattern_load_ctrl;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int AW   = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_next;
    logic       btn_load;
    logic       btn_run;
    logic [1:0] sel;
    logic [3:0] sel_onehot;
    logic       run_en;
    logic       busy;
    logic       load_done;

    int n_chk;
    int n_fail;

    pattern_load_ctrl_if #(.AW(AW), .COLS(COLS)) bus ();

    pattern_load_ctrl #(
        .ROWS(ROWS),
        .COLS(COLS),
        .AW  (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_next  (btn_next),
        .btn_load  (btn_load),
        .btn_run   (btn_run),
        .sel       (sel),
        .sel_onehot(sel_onehot),
        .run_en    (run_en),
        .busy      (busy),
        .load_done (load_done),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: one-cycle read latency, row index in the low bits
    always @(posedge clk) begin
        bus.rom_data <= 16'h5A00 | 16'(bus.rom_addr);
    end

    typedef struct {
        logic       n;
        logic       l;
        logic       r;
        logic [1:0] sel;
        logic [3:0] oh;
        logic       run;
        logic       busy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic n, input logic l, input logic r);
        btn_next = n;
        btn_load = l;
        btn_run  = r;
        tick();
        btn_next = 1'b0;
        btn_load = 1'b0;
        btn_run  = 1'b0;
        tick();
    endtask

    // Called on the first FETCH cycle; runs the load to RUN entry.
    task automatic do_load(input int stall_row, input int stall_n,
                           input int exp_cyc, input logic [1:0] exp_sel);
        int   cyc;
        int   writes;
        int   stalled;
        logic acc_prev;
        cyc      = 0;
        writes   = 0;
        stalled  = 0;
        acc_prev = 1'b0;
        bus.grid_ready = 1'b1;
        while (!run_en && cyc < 300) begin
            if (acc_prev) begin
                chk("we_after_accept", 32'(bus.grid_we), 32'd0);
            end
            acc_prev = 1'b0;
            if (bus.grid_we) begin
                if (32'(bus.grid_addr) == stall_row &&
                    stalled < stall_n) begin
                    chk("stall_we", 32'(bus.grid_we), 32'd1);
                    chk("stall_addr", 32'(bus.grid_addr),
                        32'(stall_row));
                    chk("stall_data", 32'(bus.grid_wdata),
                        32'h5A00 | 32'(stall_row));
                    bus.grid_ready = 1'b0;
                    stalled++;
                end else begin
                    bus.grid_ready = 1'b1;
                    chk("wr_addr", 32'(bus.grid_addr), 32'(writes));
                    chk("wr_data", 32'(bus.grid_wdata),
                        32'h5A00 | 32'(writes));
                    writes++;
                    acc_prev = 1'b1;
                end
            end else begin
                bus.grid_ready = 1'b1;
            end
            if (sel !== exp_sel) begin
                chk("sel_frozen", 32'(sel), 32'(exp_sel));
            end
            tick();
            cyc++;
        end
        bus.grid_ready = 1'b1;
        chk("load_cycles", 32'(cyc), 32'(exp_cyc));
        chk("load_writes", 32'(writes), 32'(ROWS));
        chk("load_done_pulse", 32'(load_done), 32'd1);
        chk("run_after_load", 32'(run_en), 32'd1);
        tick();
        chk("load_done_single", 32'(load_done), 32'd0);
        chk("run_held", 32'(run_en), 32'd1);
    endtask

    initial begin
        int k;
        n_chk  = 0;
        n_fail = 0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0};

        rst_n          = 1'b0;
        btn_next       = 1'b0;
        btn_load       = 1'b0;
        btn_run        = 1'b0;
        bus.grid_ready = 1'b1;
        #12;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_onehot", 32'(sel_onehot), 32'b0001);
        chk("rst_run_en", 32'(run_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_we", 32'(bus.grid_we), 32'd0);
        chk("rst_gaddr", 32'(bus.grid_addr), 32'd0);
        chk("rst_wdata", 32'(bus.grid_wdata), 32'd0);
        chk("rst_raddr", 32'(bus.rom_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            press(tbl[i].n, tbl[i].l, tbl[i].r);
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("vec%0d_oh", i), 32'(sel_onehot),
                32'(tbl[i].oh));
            chk($sformatf("vec%0d_run", i), 32'(run_en),
                32'(tbl[i].run));
            chk($sformatf("vec%0d_busy", i), 32'(busy),
                32'(tbl[i].busy));
        end

        // load from IDLE with sel=2, grid always ready
        press(1'b0, 1'b1, 1'b0);
        chk("load_start_busy", 32'(busy), 32'd1);
        chk("load_start_raddr", 32'(bus.rom_addr), 32'd0);
        do_load(-1, 0, 3 * ROWS, 2'd2);

        // next and load together in RUN: load wins
        press(1'b1, 1'b1, 1'b0);
        chk("nl_sel", 32'(sel), 32'd2);
        chk("nl_busy", 32'(busy), 32'd1);
        chk("nl_run_en", 32'(run_en), 32'd0);
        chk("nl_raddr", 32'(bus.rom_addr), 32'd0);
        do_load(5, 3, 3 * ROWS + 3, 2'd2);

        // buttons during a stalled WRITE of row 7, then reset mid-load
        press(1'b0, 1'b1, 1'b0);
        k = 0;
        while (!(bus.grid_we && bus.grid_addr == AW'(7)) && k < 100) begin
            tick();
            k++;
        end
        chk("row7_reached", 32'(k < 100), 32'd1);
        bus.grid_ready = 1'b0;
        btn_next = 1'b1;
        btn_load = 1'b1;
        btn_run  = 1'b1;
        tick();
        btn_next = 1'b0;
        btn_load = 1'b0;
        btn_run  = 1'b0;
        tick();
        tick();
        chk("ign_we", 32'(bus.grid_we), 32'd1);
        chk("ign_addr", 32'(bus.grid_addr), 32'd7);
        chk("ign_sel", 32'(sel), 32'd2);
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_run_en", 32'(run_en), 32'd0);
        bus.grid_ready = 1'b1;
        tick();
        chk("row8_fetch_addr", 32'(bus.rom_addr), 32'd8);
        chk("row8_fetch_we", 32'(bus.grid_we), 32'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.grid_we), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_onehot", 32'(sel_onehot), 32'b0001);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_run_en", 32'(run_en), 32'd0);
        chk("arst_raddr", 32'(bus.rom_addr), 32'd0);

        // run button held through reset gives one edge after release
        btn_run = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("held_run_early", 32'(run_en), 32'd0);
        tick();
        chk("held_run_edge", 32'(run_en), 32'd1);
        tick();
        tick();
        chk("held_run_once", 32'(run_en), 32'd1);
        btn_run = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_load_ctrl.md
PATTERN_LOAD_CTRL -- requirements
Module: pattern_load_ctrl

Interface
REQ-001 Parameter ROWS, default 16, number of grid rows loaded per pattern (power of two, 2..64).
REQ-002 Parameter COLS, default 16, width of one grid row in cells.
REQ-003 Parameter AW, default 4, row-address width, equal to log2(ROWS).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset on the following ports.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn_next  input  1  debounced level; a rising edge advances the pattern selection.
REQ-008 btn_load  input  1  debounced level; a rising edge starts loading the selected pattern.
REQ-009 btn_run  input  1  debounced level; a rising edge toggles between run and pause.
REQ-010 sel  output  2  pattern index to the pattern mux select lines (sel[1]=in1, sel[0]=in0).
REQ-011 sel_onehot  output  4  one-hot decode of sel, with bit n set when sel==n.
REQ-012 rom_addr  output  AW  row address to the selected pattern ROM.
REQ-013 rom_data  input  COLS  row data, valid exactly 1 cycle after rom_addr is presented.
REQ-014 grid_we  output  1  write request to the grid memory.
REQ-015 grid_addr  output  AW  row address being written.
REQ-016 grid_wdata  output  COLS  row data being written.
REQ-017 grid_ready  input  1  grid accepts the write in any cycle where grid_we and grid_ready are both 1.
REQ-018 run_en  output  1  high only in RUN; enables the generation stepper.
REQ-019 busy  output  1  high in FETCH, WAIT and WRITE.
REQ-020 load_done  output  1  one-cycle pulse on the cycle the FSM enters RUN after a load.

Function
REQ-021 Edge detection: each button SHALL be registered, and its edge is (current & ~previous); an edge is acted on 1 cycle after the input rises.
REQ-022 FSM states: IDLE, FETCH, WAIT, WRITE, RUN.
REQ-023 IDLE/RUN, next edge: sel SHALL increment mod 4 (3 wraps to 0).
REQ-024 IDLE/RUN, load edge: row counter cleared to 0 and FSM goes to FETCH; sel is frozen until the load completes.
REQ-025 Simultaneous next and load edges: load wins; sel is unchanged and the next edge is dropped.
REQ-026 Simultaneous run and load edges: load wins; the run edge is dropped.
REQ-027 IDLE, run edge: go to RUN. RUN, run edge: go to IDLE. run_en follows with the state (registered, no extra latency).
REQ-028 FETCH: rom_addr = row; go to WAIT next cycle.
REQ-029 WAIT: capture rom_data into the write-data register; go to WRITE.
REQ-030 WRITE: grid_we=1, grid_addr=row, grid_wdata=captured data; all three held stable while grid_ready=0.
REQ-031 WRITE with grid_ready=1, row<ROWS-1: row increments and FSM returns to FETCH; grid_we is 0 in the following cycle.
REQ-032 WRITE with grid_ready=1, row==ROWS-1: FSM goes to RUN and load_done pulses for 1 cycle; a load always auto-starts the game.
REQ-033 All button edges SHALL be ignored in FETCH, WAIT and WRITE; there is no abort and no queueing.
REQ-034 Minimum load time with grid_ready tied high: 3*ROWS cycles from the first FETCH to RUN entry (48 cycles for ROWS=16).
REQ-035 grid_we SHALL be 0 in every state except WRITE.

Reset
REQ-036 Assertion of rst_n=0 SHALL, asynchronously and at any point including mid-load, force: state=IDLE, sel=0, sel_onehot=4'b0001, row=0, rom_addr=0, grid_we=0, grid_addr=0, grid_wdata=0, run_en=0, busy=0, load_done=0, button history=0.
REQ-037 After release, a button held high through reset SHALL register one rising edge on the first clock if its previous-value register is 0 by reset.

Verification
REQ-038 After reset, pulse btn_next 5 times -> sel sequence 1,2,3,0,1; sel_onehot tracks it (final value 4'b0010).
REQ-039 sel=2, ROM returns row index in the low bits, grid_ready=1, load edge -> 16 writes, addresses 0..15 in order, data matches; load_done pulses once; run_en=1 at cycle 48.
REQ-040 grid_ready low for 3 cycles on row 5 -> grid_we, grid_addr=5 and grid_wdata held constant; row 6 does not start until the cycle after the accept.
REQ-041 In RUN, btn_next and btn_load rise on the same cycle -> sel unchanged, busy=1, run_en=0, load restarts at row 0.
REQ-042 During WRITE of row 7, btn_next, btn_run and btn_load edges -> all ignored; rst_n asserted mid-load -> grid_we=0, state IDLE and sel=0 immediately, without waiting for a clock edge.
REQ-043 IDLE, run edge -> run_en=1; a second run edge -> run_en=0; sel is unaffected throughout.
